cache_way_decoder: RTL and testbench

Way-select decoder and refill controller for the 2-way set-associative cache; the counterpart of the hit encoder. It takes the encoder's miss flag and hit-way index, and decodes them (or an internally chosen victim) into one-hot per-way write enables and a read-mux select. It maintains per-set valid bits and a 1-bit LRU, and runs the miss-refill handshake with the next memory level. It sits between the tag/way comparators and the way data/tag arrays.

---
 rtl/cache_way_decoder.sv | 167 ++++++++++++++++
 tb/tb_cache_way_decoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_way_decoder.sv
// rtl/cache_way_decoder.sv - way-select decoder and refill controller for a 2-way set-associative cache
//
// Decodes a hit way, or a victim it picks itself, into one-hot way write enables
// and a read-mux select. It keeps per-set valid bits and a 1-bit LRU, and runs
// the miss refill handshake with the next memory level.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_valid      access strobe, taken only while req_ready=1
//   req_write      access is a write
//   req_index      set index of the access
//   miss, way_f    hit encoder result (way_f meaningful when miss=0)
//   req_ready      idle, access accepted this cycle
//   way_we         one-hot way write enable (registered)
//   way_sel        way index for read mux / fill path (registered)
//   mem_req        refill request to next level (registered)
//   mem_ack        refill data available, looked at only in REFILL
//   refill_done    one-cycle pulse while the fill is written (registered)
module cache_way_decoder #(
    parameter int INDEX_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_write,
    input  logic [INDEX_W-1:0] req_index,
    input  logic               miss,
    input  logic               way_f,
    output logic               req_ready,
    output logic [1:0]         way_we,
    output logic               way_sel,
    output logic               mem_req,
    input  logic               mem_ack,
    output logic               refill_done
);

    localparam int SETS = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_FILL   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [SETS-1:0][1:0] r_valid;
    logic [SETS-1:0]      r_lru;
    logic [INDEX_W-1:0]   r_index;
    logic                 r_victim;

    logic [1:0]           r_way_we;
    logic                 r_way_sel;
    logic                 r_mem_req;
    logic                 r_refill_done;

    logic [1:0]           w_way_we_nxt;
    logic                 w_way_sel_nxt;
    logic                 w_mem_req_nxt;
    logic                 w_refill_done_nxt;
    logic [1:0]           w_set_valid;
    logic                 w_victim;
    logic                 w_hit;
    logic                 w_miss_acc;

    function automatic logic [1:0] f_onehot(input logic way);
        return {way, ~way};
    endfunction

    // Fill an empty way first; only evict by LRU when both ways hold data.
    always_comb begin
        w_set_valid = r_valid[req_index];
        if (!w_set_valid[0]) begin
            w_victim = 1'b0;
        end else if (!w_set_valid[1]) begin
            w_victim = 1'b1;
        end else begin
            w_victim = r_lru[req_index];
        end
        w_hit      = (r_state == S_IDLE) && req_valid && !miss;
        w_miss_acc = (r_state == S_IDLE) && req_valid && miss;
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_way_we_nxt      = 2'b00;
        w_way_sel_nxt     = r_way_sel;
        w_mem_req_nxt     = r_mem_req;
        w_refill_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_mem_req_nxt = 1'b0;
                if (w_hit) begin
                    w_way_sel_nxt = way_f;
                    w_way_we_nxt  = req_write ? f_onehot(way_f) : 2'b00;
                end else if (w_miss_acc) begin
                    w_mem_req_nxt = 1'b1;
                    w_state_nxt   = S_REFILL;
                end
            end
            S_REFILL: begin
                // Fill strobes are set on the ack edge so they are high
                // throughout the single FILL cycle.
                if (mem_ack) begin
                    w_mem_req_nxt     = 1'b0;
                    w_way_we_nxt      = f_onehot(r_victim);
                    w_way_sel_nxt     = r_victim;
                    w_refill_done_nxt = 1'b1;
                    w_state_nxt       = S_FILL;
                end
            end
            S_FILL: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_mem_req_nxt = 1'b0;
                w_state_nxt   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_way_we      <= 2'b00;
            r_way_sel     <= 1'b0;
            r_mem_req     <= 1'b0;
            r_refill_done <= 1'b0;
            r_valid       <= '0;
            r_lru         <= '0;
            r_index       <= '0;
            r_victim      <= 1'b0;
        end else begin
            r_way_we      <= w_way_we_nxt;
            r_way_sel     <= w_way_sel_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_refill_done <= w_refill_done_nxt;
            if (w_miss_acc) begin
                r_index  <= req_index;
                r_victim <= w_victim;
            end
            if (w_hit) begin
                r_lru[req_index] <= ~way_f;
            end
            // Tables commit when FILL ends, so a reset during REFILL leaves no trace.
            if (r_state == S_FILL) begin
                r_valid[r_index][r_victim] <= 1'b1;
                r_lru[r_index]             <= ~r_victim;
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign way_we      = r_way_we;
    assign way_sel     = r_way_sel;
    assign mem_req     = r_mem_req;
    assign refill_done = r_refill_done;

endmodule

// File: tb/tb_cache_way_decoder.sv
// tb/tb_cache_way_decoder.sv - self-checking bench for cache_way_decoder
module tb_cache_way_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_write;
    logic [3:0] req_index;
    logic       miss;
    logic       way_f;
    logic       req_ready;
    logic [1:0] way_we;
    logic       way_sel;
    logic       mem_req;
    logic       mem_ack;
    logic       refill_done;

    cache_way_decoder #(.INDEX_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_index   (req_index),
        .miss        (miss),
        .way_f       (way_f),
        .req_ready   (req_ready),
        .way_we      (way_we),
        .way_sel     (way_sel),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .refill_done (refill_done)
    );

    always #5 clk = ~clk;

    // Reference state: per-set contents and expected outputs for the current cycle.
    bit [1:0]   m_valid [16];
    bit         m_lru   [16];
    logic [1:0] exp_we;
    logic       exp_sel;
    logic       exp_mem_req;
    logic       exp_done;
    logic       exp_ready;
    bit         chk_en = 1'b0;

    int         n_chk  = 0;
    int         n_pass = 0;

    int         mr_cnt;
    int         done_cnt;
    logic [1:0] fill_we;
    logic [1:0] last_we;
    logic       last_sel;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("way_we",      32'(way_we),      32'(exp_we));
            chk("way_sel",     32'(way_sel),     32'(exp_sel));
            chk("mem_req",     32'(mem_req),     32'(exp_mem_req));
            chk("refill_done", 32'(refill_done), 32'(exp_done));
            chk("req_ready",   32'(req_ready),   32'(exp_ready));
        end
    end

    task automatic smp();
        @(negedge clk);
        if (mem_req) mr_cnt++;
        if (refill_done) begin
            done_cnt++;
            fill_we = way_we;
        end
        last_we  = way_we;
        last_sel = way_sel;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 2'b00;
            m_lru[i]   = 1'b0;
        end
        exp_we      = 2'b00;
        exp_sel     = 1'b0;
        exp_mem_req = 1'b0;
        exp_done    = 1'b0;
        exp_ready   = 1'b1;
    endtask

    task automatic rand_inputs();
        req_valid = 1'($urandom);
        req_write = 1'($urandom);
        req_index = 4'($urandom);
        miss      = 1'($urandom);
        way_f     = 1'($urandom);
    endtask

    task automatic do_idle(input bit ack);
        rand_inputs();
        req_valid = 1'b0;
        mem_ack   = ack;
        edge_step();
        exp_we   = 2'b00;
        exp_done = 1'b0;
        smp();
    endtask

    task automatic do_reset();
        rand_inputs();
        mem_ack = 1'($urandom);
        rst     = 1'b1;
        edge_step();
        rst = 1'b0;
        model_reset();
        smp();
    endtask

    task automatic do_hit(input logic [3:0] idx, input bit w, input bit wr);
        req_valid = 1'b1;
        miss      = 1'b0;
        way_f     = w;
        req_write = wr;
        req_index = idx;
        mem_ack   = 1'($urandom);
        edge_step();
        exp_we      = wr ? (w ? 2'b10 : 2'b01) : 2'b00;
        exp_sel     = w;
        exp_mem_req = 1'b0;
        exp_done    = 1'b0;
        exp_ready   = 1'b1;
        m_lru[idx]  = !w;
        smp();
    endtask

    // rst_at=k (1..dly) asserts reset on the k-th REFILL edge instead of continuing.
    task automatic do_miss(input logic [3:0] idx, input int dly, input bit early, input int rst_at);
        bit v;
        v = (m_valid[idx][0] == 1'b0) ? 1'b0 :
            (m_valid[idx][1] == 1'b0) ? 1'b1 : m_lru[idx];
        mr_cnt   = 0;
        done_cnt = 0;
        fill_we  = 2'b00;
        req_valid = 1'b1;
        miss      = 1'b1;
        req_index = idx;
        way_f     = 1'($urandom);
        req_write = 1'($urandom);
        mem_ack   = early;
        edge_step();
        exp_mem_req = 1'b1;
        exp_ready   = 1'b0;
        exp_we      = 2'b00;
        exp_done    = 1'b0;
        smp();
        for (int k = 1; k <= dly; k++) begin
            rand_inputs();
            if (rst_at == k) begin
                rst     = 1'b1;
                mem_ack = 1'b1;
                edge_step();
                rst = 1'b0;
                model_reset();
                smp();
                return;
            end
            mem_ack = (k == dly);
            edge_step();
            if (k == dly) begin
                exp_mem_req = 1'b0;
                exp_we      = v ? 2'b10 : 2'b01;
                exp_sel     = v;
                exp_done    = 1'b1;
            end
            smp();
        end
        rand_inputs();
        mem_ack = 1'($urandom);
        edge_step();
        exp_we        = 2'b00;
        exp_done      = 1'b0;
        exp_ready     = 1'b1;
        m_valid[idx][v] = 1'b1;
        m_lru[idx]    = !v;
        smp();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_index = 4'd0;
        miss      = 1'b0;
        way_f     = 1'b0;
        mem_ack   = 1'b0;
        mr_cnt    = 0;
        done_cnt  = 0;
        fill_we   = 2'b00;
        last_we   = 2'b00;
        last_sel  = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        smp();
        chk("rst_ready_lit", 32'(req_ready), 32'd1);
        chk("rst_we_lit",    32'(way_we),    32'd0);

        for (int i = 0; i < 3; i++) do_idle(1'b1);

        do_miss(4'd3, 2, 1'b0, 0);
        chk("cold_mr_cycles", 32'(mr_cnt),   32'd2);
        chk("cold_fill_we",   32'(fill_we),  32'h1);
        chk("cold_done_cnt",  32'(done_cnt), 32'd1);

        do_miss(4'd3, 1, 1'b0, 0);
        chk("second_fill_we", 32'(fill_we), 32'h2);

        do_hit(4'd3, 1'b0, 1'b1);
        chk("whit_we",      32'(last_we),  32'h1);
        chk("model_lru3",   32'(m_lru[3]), 32'd1);
        do_miss(4'd3, 1, 1'b0, 0);
        chk("lru_victim1",  32'(fill_we), 32'h2);
        do_miss(4'd3, 1, 1'b0, 0);
        chk("lru_victim0",  32'(fill_we), 32'h1);

        do_hit(4'd5, 1'b1, 1'b0);
        chk("rhit_sel", 32'(last_sel), 32'd1);
        chk("rhit_we",  32'(last_we),  32'h0);
        for (int i = 0; i < 5; i++) do_hit(4'd5, 1'($urandom), 1'b0);

        do_miss(4'd9, 3, 1'b0, 2);
        chk("rst_refill_no_done", 32'(done_cnt), 32'd0);
        do_miss(4'd3, 1, 1'b0, 0);
        chk("post_rst_victim0", 32'(fill_we), 32'h1);

        do_miss(4'd7, 1, 1'b1, 0);
        chk("early_ack_mr_cycles", 32'(mr_cnt),   32'd1);
        chk("early_ack_done",      32'(done_cnt), 32'd1);

        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 45) begin
                do_hit(4'($urandom), 1'($urandom), 1'($urandom));
            end else if (r < 75) begin
                do_miss(4'($urandom), int'($urandom_range(1, 4)), 1'($urandom), 0);
            end else if (r < 95) begin
                do_idle(1'($urandom));
            end else if (r < 98) begin
                do_miss(4'($urandom), 3, 1'($urandom), int'($urandom_range(1, 3)));
            end else begin
                do_reset();
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
